// File: rtl/tcam_lookup_engine.sv
// tcam_lookup_engine: ternary CAM lookup engine mapping packet IDs to destination IDs.
// Commands (WRITE/READ/FLUSH/SEARCH) arrive on a valid/ready channel; one operation is
// in flight at a time and its result is held on the response channel until consumed.
// Optional feature macro: TCAM_HITCNT_EN adds an 8-bit saturating hit counter per entry
// and the rsp_hitcnt output port (returned on READ, 0 otherwise).
module tcam_lookup_engine #(
    parameter int  KEY_W  = 8,
    parameter int  DATA_W = 4,
    parameter int  WORDS  = 16,
    localparam int IDX_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [IDX_W-1:0]  cmd_idx,
    input  logic [KEY_W-1:0]  cmd_key,
    input  logic [KEY_W-1:0]  cmd_mask,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_vld,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic              rsp_err,
    output logic [IDX_W-1:0]  rsp_idx,
    output logic [KEY_W-1:0]  rsp_key,
    output logic [KEY_W-1:0]  rsp_mask,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_entry_vld
`ifdef TCAM_HITCNT_EN
    ,
    output logic [7:0]        rsp_hitcnt
`endif
);

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_WRITE  = 3'd1;
    localparam logic [2:0] OP_READ   = 3'd2;
    localparam logic [2:0] OP_FLUSH  = 3'd3;
    localparam logic [2:0] OP_SEARCH = 3'd4;

    // Entry count widened by one bit so indices at or above WORDS can be detected.
    localparam logic [IDX_W:0] WORDS_L = WORDS[IDX_W:0];

    typedef enum logic [1:0] {IDLE, CMP, RESP, FLUSH} state_t;

    state_t state_reg, state_next;

    // Entry storage; only the valid bits are reset.
    logic [KEY_W-1:0]  key_mem  [WORDS];
    logic [KEY_W-1:0]  mask_mem [WORDS];
    logic [DATA_W-1:0] data_mem [WORDS];
    logic [WORDS-1:0]  valid_reg;

    logic [IDX_W-1:0]  flush_cnt_reg;
    logic [KEY_W-1:0]  skey_reg, smask_reg;

    logic              rsp_hit_reg, rsp_err_reg, rsp_entry_vld_reg;
    logic [IDX_W-1:0]  rsp_idx_reg;
    logic [KEY_W-1:0]  rsp_key_reg, rsp_mask_reg;
    logic [DATA_W-1:0] rsp_data_reg;

    logic              accept, idx_ok, is_err, wr_en, rd_en, srch_en, flush_last;
    logic [WORDS-1:0]  match;
    logic              hit;
    logic [IDX_W-1:0]  win_idx;

    assign accept     = cmd_valid && cmd_ready;
    assign idx_ok     = {1'b0, cmd_idx} < WORDS_L;
    assign is_err     = (cmd_op > OP_SEARCH) ||
                        (((cmd_op == OP_WRITE) || (cmd_op == OP_READ)) && !idx_ok);
    assign wr_en      = accept && !is_err && (cmd_op == OP_WRITE);
    assign rd_en      = accept && !is_err && (cmd_op == OP_READ);
    assign srch_en    = accept && (cmd_op == OP_SEARCH);
    assign flush_last = (flush_cnt_reg == IDX_W'(WORDS - 1));

    assign cmd_ready     = (state_reg == IDLE);
    assign rsp_valid     = (state_reg == RESP);
    assign rsp_hit       = rsp_hit_reg;
    assign rsp_err       = rsp_err_reg;
    assign rsp_idx       = rsp_idx_reg;
    assign rsp_key       = rsp_key_reg;
    assign rsp_mask      = rsp_mask_reg;
    assign rsp_data      = rsp_data_reg;
    assign rsp_entry_vld = rsp_entry_vld_reg;

    // Masked compare per entry: a bit participates only if both entry and search masks care.
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_match
        assign match[gi] = valid_reg[gi] &&
            (((key_mem[gi] ^ skey_reg) & mask_mem[gi] & smask_reg) == '0);
    end

    // Lowest-index priority encoder over the match vector.
    always_comb begin
        hit     = 1'b0;
        win_idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; errors and WRITE/READ respond directly, NOP stays idle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (is_err) begin
                        state_next = RESP;
                    end else begin
                        case (cmd_op)
                            OP_WRITE, OP_READ: state_next = RESP;
                            OP_FLUSH:          state_next = FLUSH;
                            OP_SEARCH:         state_next = CMP;
                            default:           state_next = IDLE;
                        endcase
                    end
                end
            end
            CMP:     state_next = RESP;
            FLUSH:   if (flush_last) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Key/mask/data storage writes (not reset, block-RAM style).
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_mem[cmd_idx]  <= cmd_key;
            mask_mem[cmd_idx] <= cmd_mask;
            data_mem[cmd_idx] <= cmd_data;
        end
    end

    // Valid bits and the flush sweep, which clears one entry per cycle and wraps the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg     <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (wr_en) begin
                valid_reg[cmd_idx] <= cmd_vld;
            end
            if (state_reg == FLUSH) begin
                valid_reg[flush_cnt_reg] <= 1'b0;
                flush_cnt_reg <= flush_last ? '0 : flush_cnt_reg + IDX_W'(1);
            end
        end
    end

    // Response registers: loaded at command accept, or at CMP exit with the search result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_hit_reg       <= 1'b0;
            rsp_err_reg       <= 1'b0;
            rsp_idx_reg       <= '0;
            rsp_key_reg       <= '0;
            rsp_mask_reg      <= '0;
            rsp_data_reg      <= '0;
            rsp_entry_vld_reg <= 1'b0;
            skey_reg          <= '0;
            smask_reg         <= '0;
        end else if (accept) begin
            rsp_hit_reg       <= 1'b0;
            rsp_err_reg       <= is_err;
            rsp_idx_reg       <= '0;
            rsp_key_reg       <= '0;
            rsp_mask_reg      <= '0;
            rsp_data_reg      <= '0;
            rsp_entry_vld_reg <= 1'b0;
            if (wr_en) begin
                rsp_idx_reg <= cmd_idx;
            end
            if (rd_en) begin
                rsp_idx_reg       <= cmd_idx;
                rsp_key_reg       <= key_mem[cmd_idx];
                rsp_mask_reg      <= mask_mem[cmd_idx];
                rsp_data_reg      <= data_mem[cmd_idx];
                rsp_entry_vld_reg <= valid_reg[cmd_idx];
            end
            if (srch_en) begin
                skey_reg  <= cmd_key;
                smask_reg <= cmd_mask;
            end
        end else if (state_reg == CMP) begin
            rsp_hit_reg  <= hit;
            rsp_idx_reg  <= win_idx;
            rsp_data_reg <= hit ? data_mem[win_idx] : '0;
        end
    end

`ifdef TCAM_HITCNT_EN
    logic [7:0] hit_cnt_mem [WORDS];
    logic [7:0] rsp_hitcnt_reg;

    assign rsp_hitcnt = rsp_hitcnt_reg;

    // Per-entry saturating hit counters, bumped when a search result enters RESP.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                hit_cnt_mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                hit_cnt_mem[cmd_idx] <= '0;
            end
            if (state_reg == FLUSH) begin
                hit_cnt_mem[flush_cnt_reg] <= '0;
            end
            if ((state_reg == CMP) && hit && (hit_cnt_mem[win_idx] != 8'hFF)) begin
                hit_cnt_mem[win_idx] <= hit_cnt_mem[win_idx] + 8'd1;
            end
        end
    end

    // Hit count is reported only by READ; every other response shows 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_hitcnt_reg <= '0;
        end else if (accept) begin
            rsp_hitcnt_reg <= rd_en ? hit_cnt_mem[cmd_idx] : 8'd0;
        end else if (state_reg == CMP) begin
            rsp_hitcnt_reg <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_tcam_lookup_engine.sv
// tb_tcam_lookup_engine: randomized and directed stimulus for tcam_lookup_engine with a
// reference model of the table; expected responses go into a queue that a separate
// monitor pops and compares (fields, latency, hold stability) on every response.
module tb_tcam_lookup_engine;

    localparam int WORDS = 12;
    localparam int IDX_W = $clog2(WORDS);

    logic             clk, rst_n;
    logic             cmd_valid, cmd_ready, cmd_vld;
    logic [2:0]       cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [7:0]       cmd_key, cmd_mask;
    logic [3:0]       cmd_data;
    logic             rsp_valid, rsp_ready, rsp_hit, rsp_err, rsp_entry_vld;
    logic [IDX_W-1:0] rsp_idx;
    logic [7:0]       rsp_key, rsp_mask;
    logic [3:0]       rsp_data;
`ifdef TCAM_HITCNT_EN
    logic [7:0]       rsp_hitcnt;
`endif

    tcam_lookup_engine #(.KEY_W(8), .DATA_W(4), .WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_idx(cmd_idx), .cmd_key(cmd_key), .cmd_mask(cmd_mask),
        .cmd_data(cmd_data), .cmd_vld(cmd_vld),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_err(rsp_err), .rsp_idx(rsp_idx), .rsp_key(rsp_key),
        .rsp_mask(rsp_mask), .rsp_data(rsp_data), .rsp_entry_vld(rsp_entry_vld)
`ifdef TCAM_HITCNT_EN
        , .rsp_hitcnt(rsp_hitcnt)
`endif
    );

    typedef struct {
        logic [2:0]       op;
        bit               hit, err, ev;
        logic [IDX_W-1:0] idx;
        logic [7:0]       key, mask, hc;
        logic [3:0]       data;
        int               accept, lat, hold;
    } exp_t;

    exp_t exp_q[$];

    // Reference model of the table contents.
    logic [7:0] m_key  [WORDS];
    logic [7:0] m_mask [WORDS];
    logic [3:0] m_data [WORDS];
    bit         m_vld  [WORDS];
    int         m_cnt  [WORDS];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic check_rsp(input string tag, input exp_t e);
        chk({tag, "_hit"},  rsp_hit,       e.hit);
        chk({tag, "_err"},  rsp_err,       e.err);
        chk({tag, "_idx"},  rsp_idx,       e.idx);
        chk({tag, "_key"},  rsp_key,       e.key);
        chk({tag, "_mask"}, rsp_mask,      e.mask);
        chk({tag, "_data"}, rsp_data,      e.data);
        chk({tag, "_ev"},   rsp_entry_vld, e.ev);
`ifdef TCAM_HITCNT_EN
        chk({tag, "_hitcnt"}, rsp_hitcnt, e.hc);
`endif
    endtask

    // Compute the expected response from the table rules, update the model, drive the command.
    task automatic issue(input logic [2:0] op, input int idx, input logic [7:0] key,
                         input logic [7:0] mask, input logic [3:0] data, input bit vld,
                         input int hold);
        exp_t e;
        int   n;
        bit   found;
        e.op = op; e.hit = 0; e.err = 0; e.ev = 0; e.idx = '0; e.key = '0; e.mask = '0;
        e.hc = '0; e.data = '0; e.accept = 0; e.lat = 1; e.hold = hold;
        if (op > 3'd4 || ((op == 3'd1 || op == 3'd2) && idx >= WORDS)) begin
            e.err = 1;
        end else if (op == 3'd1) begin
            m_key[idx] = key; m_mask[idx] = mask; m_data[idx] = data;
            m_vld[idx] = vld; m_cnt[idx] = 0;
            e.idx = IDX_W'(idx);
        end else if (op == 3'd2) begin
            e.idx = IDX_W'(idx); e.key = m_key[idx]; e.mask = m_mask[idx];
            e.data = m_data[idx]; e.ev = m_vld[idx]; e.hc = 8'(m_cnt[idx]);
        end else if (op == 3'd3) begin
            for (int i = 0; i < WORDS; i++) begin
                m_vld[i] = 0; m_cnt[i] = 0;
            end
            e.lat = WORDS + 1;
        end else if (op == 3'd4) begin
            found = 0;
            for (int i = 0; i < WORDS; i++) begin
                if (!found && m_vld[i] && (((m_key[i] ^ key) & m_mask[i] & mask) == 8'h00)) begin
                    found = 1; e.hit = 1; e.idx = IDX_W'(i); e.data = m_data[i];
                    if (m_cnt[i] < 255) m_cnt[i]++;
                end
            end
            e.lat = 2;
        end
        @(negedge clk);
        cmd_valid = 1; cmd_op = op; cmd_idx = IDX_W'(idx); cmd_key = key;
        cmd_mask = mask; cmd_data = data; cmd_vld = vld;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            bad++;
            $display("FAIL cmd_ready_timeout: got 0 want 1 (cycle %0d)", cyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "engine stuck");
        end
        e.accept = cyc + 1;
        if (op != 3'd0 || e.err) exp_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        exp_q.delete();
        for (int i = 0; i < WORDS; i++) begin
            m_vld[i] = 0; m_cnt[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // Monitor: scoreboard comparison, latency, hold stability and busy-ready checks.
    initial begin : monitor
        exp_t cur;
        bit   in_rsp;
        int   wait_n;
        in_rsp = 0; wait_n = 0; rsp_ready = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_rsp = 0; rsp_ready = 0;
            end else begin
                if (exp_q.size() > 0 && cyc >= exp_q[0].accept) begin
                    chk("busy_cmd_ready", cmd_ready, 0);
                    if (!rsp_valid && (cyc + 1 - exp_q[0].accept) > exp_q[0].lat + 2) begin
                        total++; bad++;
                        $display("FAIL rsp_timeout: got no response want op %0d (cycle %0d)",
                                 exp_q[0].op, cyc);
                        void'(exp_q.pop_front());
                    end
                end
                if (rsp_valid) begin
                    if (!in_rsp) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL unexpected_rsp: got rsp_valid want none (cycle %0d)", cyc);
                            rsp_ready = 1;
                            continue;
                        end
                        cur = exp_q[0];
                        in_rsp = 1;
                        wait_n = 0;
                        chk("latency", cyc + 1 - cur.accept, cur.lat);
                        check_rsp("first", cur);
                    end
                    if (wait_n >= cur.hold) begin
                        check_rsp("hs", cur);
                        rsp_ready = 1;
                        void'(exp_q.pop_front());
                        in_rsp = 0;
                        $display("rsp op=%0d hit=%0b err=%0b idx=%0d data=%0h hold=%0d",
                                 cur.op, rsp_hit, rsp_err, rsp_idx, rsp_data, cur.hold);
                    end else begin
                        rsp_ready = 0;
                        wait_n++;
                    end
                end else begin
                    rsp_ready = 0;
                end
            end
        end
    end

    // Stimulus: directed cases, hit counter saturation, random traffic, mid-flush reset.
    initial begin : stimulus
        int r, n, ki;
        logic [7:0] k, msk;
        rst_n = 0; cmd_valid = 0; cmd_op = 0; cmd_idx = '0; cmd_key = 0;
        cmd_mask = 0; cmd_data = 0; cmd_vld = 0;
        for (int i = 0; i < WORDS; i++) begin
            m_key[i] = 0; m_mask[i] = 0; m_data[i] = 0; m_vld[i] = 0; m_cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_hit", rsp_hit, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_idx", rsp_idx, 0);
        chk("rst_key", rsp_key, 0);
        chk("rst_mask", rsp_mask, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_ev", rsp_entry_vld, 0);

        issue(3'd4, 0, 8'hA5, 8'hFF, 4'h0, 0, 0);
        issue(3'd1, 3, 8'hA0, 8'hF0, 4'h7, 1, 1);
        issue(3'd4, 0, 8'hA5, 8'hFF, 4'h0, 0, 0);
        issue(3'd2, 3, 8'h00, 8'h00, 4'h0, 0, 2);
        issue(3'd1, 2, 8'hA5, 8'hFF, 4'h2, 1, 0);
        issue(3'd4, 0, 8'hA5, 8'hFF, 4'h0, 0, 0);
        issue(3'd4, 0, 8'h3C, 8'h00, 4'h0, 0, 0);
        issue(3'd2, 3, 8'h00, 8'h00, 4'h0, 0, 5);
        issue(3'd7, 0, 8'h00, 8'h00, 4'h0, 0, 0);
        issue(3'd5, 1, 8'h11, 8'h22, 4'h3, 1, 1);
        issue(3'd2, 13, 8'h00, 8'h00, 4'h0, 0, 0);
        issue(3'd1, 12, 8'hA5, 8'hFF, 4'hF, 1, 0);
        issue(3'd0, 0, 8'hA5, 8'hFF, 4'h0, 0, 0);
        issue(3'd3, 0, 8'h00, 8'h00, 4'h0, 0, 3);
        issue(3'd4, 0, 8'hA5, 8'hFF, 4'h0, 0, 0);

        issue(3'd1, 3, 8'hA0, 8'hF0, 4'h7, 1, 0);
        repeat (300) issue(3'd4, 0, 8'hA5, 8'hFF, 4'h0, 0, 0);
        issue(3'd2, 3, 8'h00, 8'h00, 4'h0, 0, 0);
        issue(3'd1, 3, 8'hA0, 8'hF0, 4'h7, 1, 0);
        issue(3'd2, 3, 8'h00, 8'h00, 4'h0, 0, 0);

        for (int i = 0; i < WORDS; i++) begin
            issue(3'd1, i, 8'($urandom), 8'($urandom & $urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0, 0);
        end
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                issue(3'd0, 0, 8'h00, 8'h00, 4'h0, 0, 0);
            end else if (r < 30) begin
                issue(3'd1, $urandom_range(0, 15), 8'($urandom), 8'($urandom & $urandom),
                      4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3));
            end else if (r < 50) begin
                issue(3'd2, $urandom_range(0, 15), 8'h00, 8'h00, 4'h0, 0, $urandom_range(0, 3));
            end else if (r < 52) begin
                issue(3'd3, 0, 8'h00, 8'h00, 4'h0, 0, $urandom_range(0, 3));
            end else if (r < 57) begin
                issue(3'($urandom_range(5, 7)), $urandom_range(0, 15), 8'($urandom),
                      8'($urandom), 4'($urandom), 1, $urandom_range(0, 3));
            end else begin
                ki  = $urandom_range(0, WORDS - 1);
                k   = m_key[ki] ^ 8'($urandom & $urandom & $urandom);
                msk = 8'($urandom | $urandom);
                issue(3'd4, 0, k, msk, 4'h0, 0, $urandom_range(0, 3));
            end
        end

        issue(3'd1, 5, 8'h5A, 8'hFF, 4'h9, 1, 0);
        issue(3'd3, 0, 8'h00, 8'h00, 4'h0, 0, 0);
        repeat (5) @(negedge clk);
        do_reset();
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        issue(3'd4, 0, 8'h5A, 8'h00, 4'h0, 0, 0);
        issue(3'd2, 5, 8'h00, 8'h00, 4'h0, 0, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcam_lookup_engine.md
Name: tcam_lookup_engine

Overview:
- Parametrised ternary-CAM lookup engine with an internal behavioural storage array of WORDS entries (key, mask, data, valid).
- Serves WRITE/READ/SEARCH/FLUSH over a valid/ready command channel and returns results on a valid/ready response channel.
- SEARCH is a two-stage pipeline: masked compare, then lowest-index priority encode and data read.
- Sits between the packet classifier and the routing table, mapping packet IDs to destination IDs.

Parameters:
KEY_W, 8, key and mask width
DATA_W, 4, payload (destination ID) width
WORDS, 16, entry count, >= 2, need not be a power of 2
IDX_W, $clog2(WORDS), index width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  engine accepts command this cycle
cmd_op  in  3  0 NOP, 1 WRITE, 2 READ, 3 FLUSH, 4 SEARCH, others illegal
cmd_idx  in  IDX_W  entry index for WRITE/READ
cmd_key  in  KEY_W  write key or search key
cmd_mask  in  KEY_W  write: entry care-mask; search: global care-mask (1 = compare bit)
cmd_data  in  DATA_W  write payload
cmd_vld  in  1  entry valid bit written on WRITE
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed
rsp_hit  out  1  SEARCH matched
rsp_err  out  1  illegal op or cmd_idx >= WORDS
rsp_idx  out  IDX_W  matched or read index
rsp_key  out  KEY_W  READ: stored key
rsp_mask  out  KEY_W  READ: stored mask
rsp_data  out  DATA_W  READ/SEARCH-hit data; 0 on miss
rsp_entry_vld  out  1  READ: stored valid bit

Behaviour:
- Reset value of every rsp_* output is 0. Reset clears all entry valid bits in one cycle; key/mask/data arrays are not reset. State goes to IDLE. Reset mid-operation aborts the operation and drops any pending response.
- FSM states: IDLE, CMP, RESP, FLUSH.
- cmd_ready = (state == IDLE). Handshake occurs when cmd_valid && cmd_ready. A command with cmd_op = NOP is accepted and ignored.
- WRITE at edge T:
  - Entry cmd_idx gets key, mask, data and vld at edge T.
  - Transition to RESP; rsp_valid at T+1 with rsp_idx = cmd_idx.
- READ at edge T: captures the entry into the rsp_* registers; RESP with rsp_valid at T+1.
- SEARCH at edge T: captures key and global mask, enters CMP.
  - In CMP, match[i] = valid[i] && (((key_i ^ skey) & mask_i & smask) == 0).
  - match is registered at T+1; go to RESP.
  - rsp_valid at T+2. rsp_hit = |match; rsp_idx = lowest set index (0 on miss); rsp_data = data[rsp_idx] on hit, else 0.
- FLUSH at edge T: enters FLUSH and clears valid[k] for k = 0..WORDS-1, one per cycle.
  - After WORDS cycles, go to RESP; rsp_valid at T+WORDS+1.
  - The internal flush counter wraps to 0 on exit.
- RESP holds all rsp_* stable until rsp_valid && rsp_ready, then returns to IDLE. The next command can be accepted in the cycle after the response handshake.
- Error cases: illegal op, or WRITE/READ with cmd_idx >= WORDS.
  - No array change.
  - rsp_err = 1, all other rsp_* = 0, rsp_valid at T+1.
- One operation is in flight at a time, so there is no write/search hazard.
- A search with all global-mask bits 0 hits the lowest valid entry.
- A search with no valid entries misses.

Optional Feature:
- Macro TCAM_HITCNT_EN.
- Defined:
  - Each entry has an 8-bit saturating hit counter.
  - The counter increments at the SEARCH RESP entry edge for the winning index only, and saturates at 255.
  - The counter is cleared by WRITE to that entry, by FLUSH and by reset.
  - Extra output port rsp_hitcnt (8 bits) returns the counter on READ and is 0 otherwise.
- Undefined: no counters, no rsp_hitcnt port, all other behaviour identical.

Test Plan:
- Reset, then SEARCH key 8'hA5, smask 8'hFF -> rsp_valid at T+2, rsp_hit 0, rsp_data 0.
- WRITE idx 3 (key 8'hA0, mask 8'hF0, data 4'h7, vld 1), then SEARCH 8'hA5/8'hFF -> hit 1, idx 3, data 7. READ idx 3 returns key A0, mask F0, entry_vld 1.
- WRITE idx 2 (key 8'hA5, mask FF, data 4'h2) and idx 3 as above, SEARCH 8'hA5 -> idx 2, data 2 (lowest index wins).
- FLUSH with WORDS = 16 -> rsp_valid exactly 17 cycles after accept; subsequent SEARCH misses; cmd_ready low throughout.
- Hold rsp_ready low 5 cycles after READ -> rsp_* stable, cmd_ready low; op 3'b111 -> rsp_err 1. With WORDS = 12, READ idx 13 -> rsp_err 1.
- With TCAM_HITCNT_EN: 300 hitting SEARCHes on idx 3 -> READ idx 3 gives rsp_hitcnt 255; after WRITE idx 3 -> 0.
